qspi_ram_responder: RTL and testbench
=====================================

QSPI_RAM_RESPONDER -- requirements
Module: qspi_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning backing-memory byte address width; upper 24-ADDR_W address bits ignored.
REQ-002 SHALL have parameter DUMMY_NIBBLES, default 6, meaning SCLK cycles between address and first read data.
REQ-003 SHALL have port clk  input  1  system clock; the only clock; SCLK SHALL be at most clk/4.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port cs_n  input  1  chip select from initiator, active-low, asynchronous to clk.
REQ-006 SHALL have port sclk  input  1  serial clock from initiator, asynchronous to clk.
REQ-007 SHALL have port io_in  input  4  IO[3:0] pad inputs.
REQ-008 SHALL have port io_out  output  4  IO[3:0] pad drive values.
REQ-009 SHALL have port io_oe  output  4  per-bit pad output enable, all bits equal.
REQ-010 SHALL have port mem_addr  output  ADDR_W  backing-memory byte address.
REQ-011 SHALL have port mem_wdata  output  8  write byte.
REQ-012 SHALL have port mem_we  output  1  one-clk write strobe.
REQ-013 SHALL have port mem_re  output  1  one-clk read strobe.
REQ-014 SHALL have port mem_rdata  input  8  read byte, valid exactly one clk after mem_re.

Function
REQ-015 cs_n, sclk, io_in SHALL pass a 2-flop synchronizer; SCLK rise/fall SHALL be detected on synchronized values, one-clk pulses.
REQ-016 All input sampling SHALL occur on SCLK rise; io_out SHALL change only on SCLK fall.
REQ-017 Nibble order SHALL be high nibble first for command, address (MSB first, 6 nibbles) and data.
REQ-018 States SHALL be IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-019 IDLE -> CMD on synchronized cs_n fall; 2 nibbles received in CMD.
REQ-020 CMD: 0xEB -> ADDR (read); 0x38 or 0x02 -> ADDR (write); any other value -> IGNORE.
REQ-021 ADDR -> DUMMY (read) or WDATA (write) after the 6th address nibble.
REQ-022 On entering DUMMY, SHALL pulse mem_re at current address; DUMMY -> RDATA after DUMMY_NIBBLES rises.
REQ-023 RDATA: on each SCLK fall drive next nibble, io_oe=4'hF; after low nibble driven, address+1 and mem_re pulsed to prefetch.
REQ-024 WDATA: every 2nd rise assembles a byte, pulses mem_we with mem_addr=current address, then address+1.
REQ-025 Address increment SHALL wrap modulo 2^ADDR_W.
REQ-026 Synchronized cs_n rise in any state SHALL force IDLE and io_oe=0 on the next clk; partial write byte discarded, no mem_we.
REQ-027 IGNORE SHALL keep io_oe=0 and ignore SCLK until cs_n rises.
REQ-028 mem_we and mem_re SHALL never assert in the same clk.
REQ-029 SCLK edges while cs_n high SHALL have no effect.

Reset
REQ-030 During rst: state=IDLE, io_oe=0, io_out=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, synchronizers cleared.
REQ-031 Reset mid-transaction SHALL abort without memory write; after release, a new cs_n fall is required before any command is accepted.

Structure
REQ-032 Package qspi_ram_pkg SHALL hold the state enum and command constants CMD_QREAD=8'hEB, CMD_QWRITE=8'h38, CMD_WRITE_ALT=8'h02.
REQ-033 Sub-module qspi_edge_sync SHALL implement the synchronizers and SCLK edge detection; the FSM and datapath remain in qspi_ram_responder.

Verification
REQ-034 Write 0x38, address 0x000010, data 0xA5 0x3C, cs_n high; then read 0xEB, address 0x000010, 6 dummy cycles -> io_out nibbles A,5,3,C; mem_we twice at 0x0010, 0x0011.
REQ-035 Command 0x9F with 8 further SCLK cycles -> io_oe stays 0; no mem_re or mem_we.
REQ-036 Write 0x38 to 0x000020, 3 data nibbles, then cs_n high -> exactly one mem_we (0x0020); next transaction decodes normally.
REQ-037 Read at 0x00FFFF with ADDR_W=16, 2 bytes -> mem_re addresses 0xFFFF then 0x0000.
REQ-038 rst asserted during read data phase -> io_oe=0 next clk; SCLK edges ignored until a new cs_n fall.

Source files
------------

// File: rtl/qspi_ram_pkg.sv
// Shared types and command codes for the quad-SPI RAM responder.
package qspi_ram_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      RDATA,
      WDATA,
      IGNORE
   } state_t;

   localparam logic [7:0] CMD_QREAD     = 8'hEB;
   localparam logic [7:0] CMD_QWRITE    = 8'h38;
   localparam logic [7:0] CMD_WRITE_ALT = 8'h02;

   localparam int ADDR_NIBBLES = 6;

   function automatic logic is_write_cmd(input logic [7:0] c);
      return (c == CMD_QWRITE) || (c == CMD_WRITE_ALT);
   endfunction

endpackage

// File: rtl/qspi_edge_sync.sv
// Brings the asynchronous pad signals into the clk domain and turns the
// synchronized chip select and serial clock into one-clk edge pulses.
module qspi_edge_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       sclk,
   input  logic [3:0] io_in,
   output logic       cs_n_s,
   output logic       cs_fall,
   output logic       cs_rise,
   output logic       sclk_rise,
   output logic       sclk_fall,
   output logic [3:0] io_s
);

   // Bit layout of both synchronizer ranks: {cs_n, sclk, io[3:0]}
   logic [5:0] meta_q, meta_d;
   logic [5:0] sync_q, sync_d;
   logic       cs_prev_q, cs_prev_d;
   logic       sclk_prev_q, sclk_prev_d;

   always_comb begin
      meta_d      = {cs_n, sclk, io_in};
      sync_d      = meta_q;
      cs_prev_d   = sync_q[5];
      sclk_prev_d = sync_q[4];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q      <= '0;
         sync_q      <= '0;
         cs_prev_q   <= 1'b0;
         sclk_prev_q <= 1'b0;
      end else begin
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         cs_prev_q   <= cs_prev_d;
         sclk_prev_q <= sclk_prev_d;
      end
   end

   assign cs_n_s    = sync_q[5];
   assign cs_fall   = cs_prev_q & ~sync_q[5];
   assign cs_rise   = ~cs_prev_q & sync_q[5];
   assign sclk_rise = ~sclk_prev_q & sync_q[4];
   assign sclk_fall = sclk_prev_q & ~sync_q[4];
   assign io_s      = sync_q[3:0];

endmodule

// File: rtl/qspi_ram_responder.sv
// Quad-SPI RAM target: decodes quad read/write commands from an external
// initiator and turns them into byte accesses on a synchronous memory port.
module qspi_ram_responder #(
   parameter int ADDR_W        = 16,
   parameter int DUMMY_NIBBLES = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs_n,
   input  logic              sclk,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic [3:0]        io_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata
);
   import qspi_ram_pkg::*;

   localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_NIBBLES - 1);
   localparam logic [7:0] ADDR_LAST  = 8'(ADDR_NIBBLES - 1);

   logic              cs_n_s, cs_fall, cs_rise;
   logic              sclk_rise_raw, sclk_fall_raw;
   logic              sclk_rise, sclk_fall;
   logic [3:0]        io_s;
   logic [7:0]        cmd_byte;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              is_wr_q, is_wr_d;
   logic              hi_q, hi_d;
   logic              oe_q, oe_d;
   logic [3:0]        io_out_q, io_out_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_re_q, mem_re_d;
   logic              rd_pend_q, rd_pend_d;
   logic [3:0]        nib_q, nib_d;
   logic [7:0]        rdata_q, rdata_d;

   qspi_edge_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .cs_n      (cs_n),
      .sclk      (sclk),
      .io_in     (io_in),
      .cs_n_s    (cs_n_s),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .sclk_rise (sclk_rise_raw),
      .sclk_fall (sclk_fall_raw),
      .io_s      (io_s)
   );

   // SCLK activity only counts while the target is selected
   assign sclk_rise = sclk_rise_raw & ~cs_n_s;
   assign sclk_fall = sclk_fall_raw & ~cs_n_s;
   assign cmd_byte  = {nib_q, io_s};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_wr_d     = is_wr_q;
      hi_d        = hi_q;
      oe_d        = oe_q;
      io_out_d    = io_out_q;
      addr_d      = addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      rd_pend_d   = mem_re_q;
      nib_d       = nib_q;
      rdata_d     = rdata_q;

      if (rd_pend_q) rdata_d = mem_rdata;
      // Post-increment one clk after the write strobe so mem_addr is stable during it
      if (mem_we_q) addr_d = addr_q + ADDR_W'(1);

      if (cs_rise) begin
         state_d = IDLE;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_d = CMD;
                  cnt_d   = '0;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  if (cnt_q == 8'd0) begin
                     nib_d = io_s;
                     cnt_d = 8'd1;
                  end else begin
                     cnt_d = '0;
                     if (cmd_byte == CMD_QREAD) begin
                        is_wr_d = 1'b0;
                        state_d = ADDR;
                     end else if (is_write_cmd(cmd_byte)) begin
                        is_wr_d = 1'b1;
                        state_d = ADDR;
                     end else begin
                        state_d = IGNORE;
                     end
                  end
               end
            end
            ADDR: begin
               // Shifting all 24 address bits through ADDR_W keeps only the low bits
               if (sclk_rise) begin
                  addr_d = {addr_q[ADDR_W-5:0], io_s};
                  if (cnt_q == ADDR_LAST) begin
                     cnt_d = '0;
                     hi_d  = 1'b1;
                     if (is_wr_q) begin
                        state_d = WDATA;
                     end else begin
                        state_d  = DUMMY;
                        mem_re_d = 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            DUMMY: begin
               if (sclk_rise) begin
                  if (cnt_q == DUMMY_LAST) begin
                     cnt_d   = '0;
                     hi_d    = 1'b1;
                     state_d = RDATA;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
            end
            RDATA: begin
               if (sclk_fall) begin
                  oe_d = 1'b1;
                  if (hi_q) begin
                     io_out_d = rdata_q[7:4];
                     hi_d     = 1'b0;
                  end else begin
                     io_out_d = rdata_q[3:0];
                     hi_d     = 1'b1;
                     addr_d   = addr_q + ADDR_W'(1);
                     mem_re_d = 1'b1;
                  end
               end
            end
            WDATA: begin
               if (sclk_rise) begin
                  if (hi_q) begin
                     nib_d = io_s;
                     hi_d  = 1'b0;
                  end else begin
                     mem_wdata_d = {nib_q, io_s};
                     mem_we_d    = 1'b1;
                     hi_d        = 1'b1;
                  end
               end
            end
            IGNORE: begin
               oe_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
               oe_d    = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         is_wr_q     <= 1'b0;
         hi_q        <= 1'b1;
         oe_q        <= 1'b0;
         io_out_q    <= '0;
         addr_q      <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         rd_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_wr_q     <= is_wr_d;
         hi_q        <= hi_d;
         oe_q        <= oe_d;
         io_out_q    <= io_out_d;
         addr_q      <= addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

   // Nibble and read-byte holding registers are qualified by the FSM, so no reset
   always_ff @(posedge clk) begin
      nib_q   <= nib_d;
      rdata_q <= rdata_d;
   end

   assign io_out    = io_out_q;
   assign io_oe     = {4{oe_q}};
   assign mem_addr  = addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Directed bench for the quad-SPI RAM responder with a queue-based scoreboard.
module tb_qspi_ram_responder;

   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cs_n = 1'b1;
   logic        sclk = 1'b0;
   logic [3:0]  io_in = 4'h0;
   logic [3:0]  io_out;
   logic [3:0]  io_oe;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata = 8'h00;

   logic [7:0]  mem [0:65535];

   int tests = 0;
   int fails = 0;

   logic [23:0] we_exp [$];
   logic [15:0] re_exp [$];
   logic [3:0]  rd_exp [$];

   logic [23:0] we_e;
   logic [15:0] re_e;
   logic [3:0]  rd_e;

   qspi_ram_responder #(.ADDR_W(16), .DUMMY_NIBBLES(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .cs_n      (cs_n),
      .sclk      (sclk),
      .io_in     (io_in),
      .io_out    (io_out),
      .io_oe     (io_oe),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got %0h, required no event", name, act);
   endtask

   // Memory-port monitor
   always @(negedge clk) begin
      if (!rst && (mem_we || mem_re)) begin
         check("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
         if (mem_we) begin
            if (we_exp.size() == 0) unexpected("unexpected_mem_we", 32'(mem_addr));
            else begin
               we_e = we_exp.pop_front();
               check("mem_we_addr", 32'(mem_addr), 32'(we_e[23:8]));
               check("mem_we_data", 32'(mem_wdata), 32'(we_e[7:0]));
            end
         end
         if (mem_re) begin
            if (re_exp.size() == 0) unexpected("unexpected_mem_re", 32'(mem_addr));
            else begin
               re_e = re_exp.pop_front();
               check("mem_re_addr", 32'(mem_addr), 32'(re_e));
            end
         end
      end
   end

   // Read-data monitor: the initiator samples IO on its SCLK rise
   always @(posedge sclk) begin
      if (!cs_n && io_oe == 4'hF) begin
         if (rd_exp.size() == 0) unexpected("unexpected_read_nibble", 32'(io_out));
         else begin
            rd_e = rd_exp.pop_front();
            check("read_nibble", 32'(io_out), 32'(rd_e));
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic sclk_cycle(input logic [3:0] nib);
      io_in = nib;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      sclk_cycle(b[7:4]);
      sclk_cycle(b[3:0]);
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 5; i >= 0; i--) sclk_cycle(a[i*4 +: 4]);
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (3) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic write_txn(input logic [7:0] cmd, input logic [23:0] a,
                            input logic [15:0] d, input int nnib);
      cs_low();
      send_byte(cmd);
      send_addr(a);
      for (int i = 0; i < nnib; i++) sclk_cycle(d[15-4*i -: 4]);
      cs_high();
   endtask

   task automatic read_txn(input logic [23:0] a, input int nbytes);
      cs_low();
      send_byte(8'hEB);
      send_addr(a);
      repeat (6) sclk_cycle(4'h0);
      repeat (2*nbytes) sclk_cycle(4'h0);
      cs_high();
   endtask

   initial begin
      mem[16'hFFFF] = 8'h7E;
      mem[16'h0000] = 8'hD1;

      // Reset values
      repeat (5) @(negedge clk);
      check("rst_io_oe", 32'(io_oe), 32'h0);
      check("rst_io_out", 32'(io_out), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_re", 32'(mem_re), 32'h0);
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // SCLK while deselected: a full write-looking sequence must do nothing
      sclk_cycle(4'h3); sclk_cycle(4'h8);
      for (int i = 0; i < 6; i++) sclk_cycle(4'h1);
      sclk_cycle(4'hF); sclk_cycle(4'hF);
      check("desel_io_oe", 32'(io_oe), 32'h0);

      // Write A5 3C at 0x0010, then read them back
      we_exp.push_back({16'h0010, 8'hA5});
      we_exp.push_back({16'h0011, 8'h3C});
      write_txn(8'h38, 24'h000010, 16'hA53C, 4);
      re_exp.push_back(16'h0010);
      re_exp.push_back(16'h0011);
      re_exp.push_back(16'h0012);
      rd_exp.push_back(4'hA); rd_exp.push_back(4'h5);
      rd_exp.push_back(4'h3); rd_exp.push_back(4'hC);
      read_txn(24'h000010, 2);

      // Unknown command 0x9F: target stays off the bus
      cs_low();
      send_byte(8'h9F);
      for (int i = 0; i < 8; i++) sclk_cycle(4'(i + 7));
      check("ignore_io_oe", 32'(io_oe), 32'h0);
      cs_high();

      // Partial write byte discarded on deselect
      we_exp.push_back({16'h0020, 8'h96});
      write_txn(8'h38, 24'h000020, 16'h9640, 3);
      check("partial_no_oe", 32'(io_oe), 32'h0);
      // Alternate write opcode decodes normally afterwards
      we_exp.push_back({16'h0030, 8'h5A});
      write_txn(8'h02, 24'h000030, 16'h5A00, 2);
      re_exp.push_back(16'h0020);
      re_exp.push_back(16'h0021);
      rd_exp.push_back(4'h9); rd_exp.push_back(4'h6);
      read_txn(24'h000020, 1);

      // Address wrap at the top of a 16-bit space
      re_exp.push_back(16'hFFFF);
      re_exp.push_back(16'h0000);
      re_exp.push_back(16'h0001);
      rd_exp.push_back(4'h7); rd_exp.push_back(4'hE);
      rd_exp.push_back(4'hD); rd_exp.push_back(4'h1);
      read_txn(24'h00FFFF, 2);

      // Reset during the read data phase
      re_exp.push_back(16'h0010);
      re_exp.push_back(16'h0011);
      rd_exp.push_back(4'hA); rd_exp.push_back(4'h5);
      cs_low();
      send_byte(8'hEB);
      send_addr(24'h000010);
      repeat (6) sclk_cycle(4'h0);
      sclk_cycle(4'h0);
      sclk_cycle(4'h0);
      repeat (2) @(negedge clk);
      check("pre_rst_io_oe", 32'(io_oe), 32'hF);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_io_oe", 32'(io_oe), 32'h0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      send_byte(8'h38);
      send_addr(24'h000040);
      send_byte(8'h11);
      check("post_rst_io_oe", 32'(io_oe), 32'h0);
      cs_high();
      // Recovery: fresh transaction works
      re_exp.push_back(16'h0010);
      re_exp.push_back(16'h0011);
      rd_exp.push_back(4'hA); rd_exp.push_back(4'h5);
      read_txn(24'h000010, 1);

      repeat (20) @(negedge clk);
      check("we_queue_empty", 32'(we_exp.size()), 32'd0);
      check("re_queue_empty", 32'(re_exp.size()), 32'd0);
      check("rd_queue_empty", 32'(rd_exp.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
